// File: rtl/mux4x9_pkg.sv
// Shared types, widths and the round-robin pick for the 4x9 sample-path arbiter.
package mux4x9_pkg;

    localparam int CH_W      = 2;
    localparam int N_CH      = 4;
    localparam int DATA_W    = 9;
    localparam int CNT_W     = 4;
    localparam int BURST_MIN = 1;
    localparam int BURST_MAX = 15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Nearest set request after 'last', wrapping mod 4; returns 'last' when nothing is requesting.
    function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                                input logic [CH_W-1:0] last);
        logic [CH_W-1:0] idx;
        rr_pick = last;
        for (int i = N_CH; i >= 1; i--) begin
            idx = last + CH_W'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/mux4x9_arb_mux.sv
// Four-to-one 9-bit sample multiplexer; the arbiter drives its select.
module mux4x9_arb_mux
    import mux4x9_pkg::*;
(
    input  logic [CH_W-1:0]   sel_i,
    input  logic [DATA_W-1:0] d0_i,
    input  logic [DATA_W-1:0] d1_i,
    input  logic [DATA_W-1:0] d2_i,
    input  logic [DATA_W-1:0] d3_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = d0_i;
        case (sel_i)
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            2'd3:    y_o = d3_i;
            default: y_o = d0_i;
        endcase
    end

endmodule

// File: rtl/mux4x9_arb.sv
// Round-robin burst arbiter sharing one 9-bit sample path between four sources,
// with a single registered output stage toward the downstream consumer.
module mux4x9_arb
    import mux4x9_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_CH-1:0]   REQ,
    input  logic [DATA_W-1:0] D0,
    input  logic [DATA_W-1:0] D1,
    input  logic [DATA_W-1:0] D2,
    input  logic [DATA_W-1:0] D3,
    output logic [N_CH-1:0]   ACK,
    output logic [CH_W-1:0]   S,
    output logic [DATA_W-1:0] Y,
    output logic              YV,
    input  logic              YR,
    output logic [CH_W-1:0]   CH,
    output logic              BUSY,
    output state_e            dbg_state_o
);

    // Out-of-range BURST values saturate to the legal 1..15 window.
    localparam int BURST_EFF = (BURST < BURST_MIN) ? BURST_MIN :
                               (BURST > BURST_MAX) ? BURST_MAX : BURST;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_EFF - 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     s_q, s_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic                yv_q, yv_d;
    logic [DATA_W-1:0]   mux_y;
    logic                free;
    logic                capture;

    mux4x9_arb_mux u_mux4x9 (
        .sel_i (s_q),
        .d0_i  (D0),
        .d1_i  (D1),
        .d2_i  (D2),
        .d3_i  (D3),
        .y_o   (mux_y)
    );

    // Handshakes: a source word moves when ACK[i] is high at a rising edge; the output
    // word moves when YV & YR at a rising edge. A new word is taken only when the stage is free.
    assign free = !yv_q || YR;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        last_d  = last_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        yv_d    = yv_q;
        ACK     = '0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|REQ) begin
                    s_d     = rr_pick(REQ, last_q);
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!REQ[s_q]) begin
                    state_d = ST_IDLE;
                    last_d  = s_q;
                end else if (free) begin
                    capture  = 1'b1;
                    ACK[s_q] = 1'b1;
                    y_d      = mux_y;
                    yv_d     = 1'b1;
                    ch_d     = s_q;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == BURST_LAST) begin
                        state_d = ST_IDLE;
                        last_d  = s_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The pending word leaves without replacement.
        if (!capture && yv_q && YR) yv_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            last_q  <= CH_W'(N_CH - 1);
            ch_q    <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
        end
    end

    assign S           = s_q;
    assign Y           = y_q;
    assign YV          = yv_q;
    assign CH          = ch_q;
    assign BUSY        = (state_q == ST_GRANT);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux4x9_arb.sv
// Directed bench for mux4x9_arb: one task per scenario, inline checks, one summary line.
module tb_mux4x9_arb;
    import mux4x9_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  req;
    logic [8:0]  d [4];
    logic        yr;
    logic [3:0]  ack;
    logic [1:0]  s;
    logic [8:0]  y;
    logic        yv;
    logic [1:0]  ch;
    logic        busy;
    state_e      dbg;

    logic [3:0]  b_req;
    logic        b_yr;
    logic [3:0]  b_ack;
    logic [1:0]  b_s;
    logic [8:0]  b_y;
    logic        b_yv;
    logic [1:0]  b_ch;
    logic        b_busy;
    state_e      b_dbg;

    int checks   = 0;
    int failures = 0;
    logic [10:0] exp_q[$];

    mux4x9_arb #(.BURST(4)) dut (
        .CLK(clk), .RST_N(rst_n), .REQ(req),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .ACK(ack), .S(s), .Y(y), .YV(yv), .YR(yr), .CH(ch), .BUSY(busy),
        .dbg_state_o(dbg)
    );

    mux4x9_arb #(.BURST(1)) dut_b1 (
        .CLK(clk), .RST_N(rst_n), .REQ(b_req),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .ACK(b_ack), .S(b_s), .Y(b_y), .YV(b_yv), .YR(b_yr), .CH(b_ch), .BUSY(b_busy),
        .dbg_state_o(b_dbg)
    );

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        b_req = '0;
        yr    = 1'b1;
        b_yr  = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'hF;
        b_req = 4'hF;
        yr    = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 9'h1FF;
        #2;
        checks++;
        if ({ack, s, y, yv, ch, busy} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h expected 0", {ack, s, y, yv, ch, busy});
        end
        checks++;
        if (dbg !== ST_IDLE || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got dbg=%0d b_busy=%0b expected 0/0", dbg, b_busy);
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || yv !== 1'b0 || ack !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle_noreq: got busy=%0b yv=%0b ack=%0h expected 0/0/0", busy, yv, ack);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [3:0] exp_ack;
        logic       exp_busy;
        apply_reset();
        req  = 4'b0100;
        d[2] = 9'h0A5;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got ack=%0h busy=%0b expected 0/0", ack, busy);
        end
        @(posedge clk);
        #1;
        for (int it = 1; it <= 6; it++) begin
            @(negedge clk);
            exp_ack  = (it != 5) ? 4'b0100 : 4'b0000;
            exp_busy = (it != 5);
            checks++;
            if (ack !== exp_ack || busy !== exp_busy) begin
                failures++;
                $display("FAIL single_ack_c%0d: got ack=%0h busy=%0b expected %0h/%0b",
                         it, ack, busy, exp_ack, exp_busy);
            end
            if (it == 1) begin
                checks++;
                if (s !== 2'd2) begin
                    failures++;
                    $display("FAIL single_sel: got %0d expected 2", s);
                end
            end
            if (it == 2) begin
                checks++;
                if (yv !== 1'b1 || ch !== 2'd2 || y !== 9'h0A5) begin
                    failures++;
                    $display("FAIL single_word: got yv=%0b ch=%0d y=%0h expected 1/2/a5", yv, ch, y);
                end
            end
            @(posedge clk);
            #1;
        end
        req = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_all_requesting();
        int         n [4];
        int         c;
        logic [3:0] a;
        logic       multi_hot;
        logic [10:0] e;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            d[i] = 9'(i * 64);
            n[i] = 0;
        end
        exp_q.delete();
        for (int g = 0; g < 5; g++) begin
            c = g % 4;
            for (int w = 0; w < 4; w++) begin
                exp_q.push_back({2'(c), 9'(c * 64 + n[c])});
                n[c]++;
            end
        end
        multi_hot = 1'b0;
        req = 4'hF;
        yr  = 1'b1;
        for (int it = 0; it <= 25; it++) begin
            @(negedge clk);
            a = ack;
            if ($countones(ack) > 1) multi_hot = 1'b1;
            if (yv && yr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL all_extra_word: got ch=%0d y=%0h expected none", ch, y);
                end else begin
                    e = exp_q.pop_front();
                    if ({ch, y} !== e) begin
                        failures++;
                        $display("FAIL all_xfer: got ch=%0d y=%0h expected ch=%0d y=%0h",
                                 ch, y, e[10:9], e[8:0]);
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (a[i]) d[i] = d[i] + 9'd1;
        end
        checks++;
        if (multi_hot !== 1'b0) begin
            failures++;
            $display("FAIL all_onehot: got multi_hot=%0b expected 0", multi_hot);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL all_missing: got %0d words left expected 0", exp_q.size());
        end
        req = '0;
    endtask

    task automatic test_backpressure();
        logic [3:0]  a;
        int          acks;
        logic [10:0] e;
        apply_reset();
        d[1] = 9'h101;
        exp_q.delete();
        for (int w = 0; w < 4; w++) exp_q.push_back({2'd1, 9'(9'h101 + w)});
        acks = 0;
        req  = 4'b0010;
        for (int it = 0; it <= 13; it++) begin
            yr = (it >= 3 && it <= 7) ? 1'b0 : 1'b1;
            @(negedge clk);
            a = ack;
            if (it >= 3 && it <= 7) begin
                checks++;
                if (ack !== 4'b0 || y !== 9'h102 || ch !== 2'd1 || yv !== 1'b1 || s !== 2'd1) begin
                    failures++;
                    $display("FAIL bp_stall_c%0d: got ack=%0h y=%0h ch=%0d yv=%0b s=%0d expected 0/102/1/1/1",
                             it, ack, y, ch, yv, s);
                end
            end
            if (a[1]) acks++;
            if (yv && yr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra_word: got y=%0h expected none", y);
                end else begin
                    e = exp_q.pop_front();
                    if ({ch, y} !== e) begin
                        failures++;
                        $display("FAIL bp_xfer: got ch=%0d y=%0h expected ch=%0d y=%0h",
                                 ch, y, e[10:9], e[8:0]);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (a[1]) d[1] = d[1] + 9'd1;
            if (acks == 4) req = '0;
        end
        checks++;
        if (acks != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_total: got acks=%0d left=%0d expected 4/0", acks, exp_q.size());
        end
        yr = 1'b1;
    endtask

    task automatic test_early_release();
        logic [3:0] a;
        int         acks;
        apply_reset();
        d[3] = 9'h033;
        acks = 0;
        req  = 4'b1000;
        for (int it = 0; it <= 5; it++) begin
            @(negedge clk);
            a = ack;
            if (it == 1) begin
                checks++;
                if (s !== 2'd3 || ack !== 4'b1000) begin
                    failures++;
                    $display("FAIL early_first: got s=%0d ack=%0h expected 3/8", s, ack);
                end
            end
            if (it == 3) begin
                checks++;
                if (ack !== 4'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL early_noack: got ack=%0h busy=%0b expected 0/1", ack, busy);
                end
            end
            if (it == 4) begin
                checks++;
                if (ack !== 4'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL early_idle: got ack=%0h busy=%0b expected 0/0", ack, busy);
                end
            end
            if (it == 5) begin
                checks++;
                if (s !== 2'd0 || ack !== 4'b0001) begin
                    failures++;
                    $display("FAIL early_next: got s=%0d ack=%0h expected 0/1", s, ack);
                end
            end
            if (a[3]) acks++;
            @(posedge clk);
            #1;
            if (a[3]) d[3] = d[3] + 9'd1;
            if (acks == 2 && req == 4'b1000) req = 4'b0011;
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        d[1] = 9'h1AB;
        req  = 4'b0110;
        yr   = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010) begin
            failures++;
            $display("FAIL rst_pre_ack: got %0h expected 2", ack);
        end
        @(posedge clk);
        #1;
        yr = 1'b0;
        @(negedge clk);
        checks++;
        if (yv !== 1'b1 || y !== 9'h1AB || s !== 2'd1) begin
            failures++;
            $display("FAIL rst_pre_state: got yv=%0b y=%0h s=%0d expected 1/1ab/1", yv, y, s);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({yv, ack, s, y, ch, busy} !== 19'd0) begin
            failures++;
            $display("FAIL rst_async_zero: got yv=%0b ack=%0h s=%0d y=%0h ch=%0d busy=%0b expected all 0",
                     yv, ack, s, y, ch, busy);
        end
        #1;
        rst_n = 1'b1;
        yr    = 1'b1;
        #1;
        checks++;
        if (ack !== 4'b0 || yv !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_ack: got ack=%0h yv=%0b expected 0/0", ack, yv);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (s !== 2'd1 || ack !== 4'b0010 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_regrant: got s=%0d ack=%0h busy=%0b expected 1/2/1", s, ack, busy);
        end
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic test_burst1();
        logic [3:0] exp_ack;
        logic [1:0] exp_ch;
        apply_reset();
        d[1]  = 9'h011;
        d[3]  = 9'h033;
        b_req = 4'b1010;
        b_yr  = 1'b1;
        for (int it = 0; it <= 7; it++) begin
            @(negedge clk);
            exp_ack = (it % 2 == 1) ? (((it / 2) % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
            checks++;
            if (b_ack !== exp_ack) begin
                failures++;
                $display("FAIL b1_ack_c%0d: got %0h expected %0h", it, b_ack, exp_ack);
            end
            if (it >= 2 && it % 2 == 0) begin
                exp_ch = ((it / 2) % 2 == 1) ? 2'd1 : 2'd3;
                checks++;
                if (b_ch !== exp_ch || b_yv !== 1'b1 || b_dbg !== ST_IDLE) begin
                    failures++;
                    $display("FAIL b1_word_c%0d: got ch=%0d yv=%0b st=%0d expected %0d/1/0",
                             it, b_ch, b_yv, b_dbg, exp_ch);
                end
            end
            @(posedge clk);
            #1;
        end
        b_req = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        b_req = '0;
        yr    = 1'b1;
        b_yr  = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = '0;
        test_reset();
        test_single();
        test_all_requesting();
        test_backpressure();
        test_early_release();
        test_reset_mid();
        test_burst1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4x9_arb.md
# mux4x9_arb

Round-robin arbiter and sequencer that shares a single 9-bit sample path between four requesters. It drives the 2-bit select of a `MUX4X9` datapath instance and registers the selected word into one output stage with a valid/ready handshake. Each requester gets a burst of up to `BURST` words per grant. The block sits between the four sample sources (DSP channels) and the single downstream consumer (DAC/serial formatter).

## Interface
- `BURST`, default 4: maximum words transferred per grant; legal range 1..15.
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `REQ`  in  4  per-channel request; bit i high means `Di` holds a valid word.
- `D0`,`D1`,`D2`,`D3`  in  9 each  channel data; held stable while `REQ[i]` is high and un-acked.
- `ACK`  out  4  one-hot; `ACK[i]` high means `Di` is captured at this edge, so the source advances.
- `S`  out  2  mux select, registered; index of the granted channel.
- `Y`  out  9  registered output word.
- `YV`  out  1  `Y` valid.
- `YR`  in  1  downstream ready; a transfer occurs on an edge where `YV & YR`.
- `CH`  out  2  channel index of the word in `Y`.
- `BUSY`  out  1  high while in GRANT.

## Operation
- **States:** IDLE, GRANT.
- **Reset values:**
  - State IDLE.
  - `S`=0, `Y`=0, `YV`=0, `CH`=0, `ACK`=0, `BUSY`=0.
  - Burst counter `cnt`=0.
  - Last-granted pointer `last`=3, so channel 0 wins first.
- **IDLE:**
  - If `REQ`≠0, select the first set bit searching `last+1, last+2, …` mod 4.
  - Load `S` with that index, clear `cnt`, go to GRANT.
  - If `REQ`=0, stay in IDLE.
- **Output stage free:** `free = !YV | YR`.
- **GRANT capture:** when `free & REQ[S]`:
  - `ACK[S]`=1 (combinational from state, `REQ`, `YV`, `YR`).
  - `Y<=mux(S)`, `YV<=1`, `CH<=S`, `cnt<=cnt+1`.
- **GRANT release:** go to IDLE with `last<=S` when either:
  - a capture occurs with `cnt==BURST-1`, or
  - `REQ[S]` is low. No ACK is issued in that cycle, even if the output stage is free.
- **No capture:** when `!free` or `!REQ[S]`, `ACK`=0.
- **Drain:** if there is no capture and `YV & YR`, then `YV<=0`.
- **Width/arithmetic:** `cnt` is 4 bits and only increments on capture. `last` and `S` wrap mod 4.

## Timing
- **Latency:**
  - `REQ` rises in IDLE at edge n; `S` is valid after n.
  - `ACK` is issued in cycle n+1 if the output stage is free.
  - `Y`/`YV` are valid after edge n+1.
- **Throughput:** `BURST` words per `BURST+1` cycles with `YR` held high. The IDLE arbitration cycle is the single bubble per grant.
- **Backpressure:** `YR`=0 with `YV`=1 means no ACK. `Y`, `CH` and `cnt` hold. `S` stays on the same channel.
- **REQ drop:**
  - If `REQ[S]` falls while stalled, the grant releases without transfer.
  - The word in `Y` is still delivered.
- **Simultaneous requests:** all four requesting continuously yields grant order 0,1,2,3,0,…, each for `BURST` words.
- **`BURST`=1:** exactly one word per grant, then rotation.
- **Asynchronous reset mid-burst:** all outputs go to their reset values immediately. A pending `Y` is discarded. No ACK is issued after `RST_N` deasserts until a new grant.
- **Mux output:** `Y` never changes while `YV & !YR`.

## Structure
- **Shared package `mux4x9_pkg`:**
  - State encoding constants IDLE/GRANT.
  - Channel-index width (2) and data width (9).
  - `BURST` range limits.
  - Round-robin pick function (4-bit request, 2-bit last → 2-bit index).
- **Sub-module:** one `MUX4X9` instance forms the data path, with `S` driving its select. The arbiter contains only control and the output register.

## Test plan
- **Single requester:** reset, `REQ`=4'b0100, `D2`=9'h0A5, `YR`=1.
  - `S`=2 one cycle after `REQ`.
  - `ACK[2]` in the next cycle.
  - `Y`=9'h0A5, `CH`=2, `YV`=1.
  - 4 ACKs, then one idle cycle, then a re-grant to 2.
- **All requesting:** `REQ`=4'hF, `BURST`=4, `YR`=1, each source incrementing its data on ACK.
  - `CH` sequence 0×4, 1×4, 2×4, 3×4, 0×4.
  - `ACK` never multi-hot.
- **Backpressure:** during a grant to ch1, hold `YR`=0 for 5 cycles.
  - `ACK`=0 throughout, `Y` and `CH` stable.
  - Transfer resumes on `YR`=1 with no lost or duplicated word; the burst still totals 4.
- **Early release:** ch3 drops `REQ` after 2 ACKs.
  - Grant releases immediately.
  - The next grant goes to the next requester after 3 (ch0 if requesting).
- **Reset mid-burst:** pulse `RST_N` low asynchronously between edges while `YV`=1.
  - `YV`, `ACK`, `S`, `Y` are 0 immediately.
  - After release, the first grant goes to the lowest requester starting from ch0.
- **`BURST`=1:** with `REQ`=4'b1010, grants alternate 1,3,1,3, one word each.
